// File: rtl/pool_pkg.sv
// Shared constants and window indexing for the 9x9 pooling window path.
package pool_pkg;
  localparam int K       = 9;
  localparam int LB_ROWS = K - 1;

  // Flattened element index of window element (r,c); r=0 top row, c=0 leftmost.
  function automatic int win_idx(input int r, input int c);
    return r * K + c;
  endfunction
endpackage

// File: rtl/pool_window_stream9_if.sv
// Pixel-in / window-out valid-ready bundle; master drives pixels and consumes windows.
interface pool_window_stream9_if #(parameter int DATA_WIDTH = 16);
  import pool_pkg::*;

  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [0:K*K*DATA_WIDTH-1]   out_window;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_last
  );
endinterface

// File: rtl/pool_line_buffer.sv
// Eight-row column-shift line buffer: reads column col_i, pushes din_i in at the bottom on wr_en_i.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 20,
  parameter int CW         = $clog2(IMG_W)
) (
  input  logic                                  clk,
  input  logic                                  wr_en_i,
  input  logic [CW-1:0]                         col_i,
  input  logic [DATA_WIDTH-1:0]                 din_i,
  output logic [LB_ROWS-1:0][DATA_WIDTH-1:0]    col_o
);

  // No reset: every entry is rewritten before it can reach a window.
  logic [DATA_WIDTH-1:0] lb_q [LB_ROWS][IMG_W];

  always_comb begin
    for (int k = 0; k < LB_ROWS; k++) begin
      col_o[k] = lb_q[k][col_i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < LB_ROWS - 1; k++) begin
        lb_q[k][col_i] <= lb_q[k+1][col_i];
      end
      lb_q[LB_ROWS-1][col_i] <= din_i;
    end
  end

endmodule

// File: rtl/pool_window_stream9.sv
// Raster pixel stream to stride-1 9x9 windows; window visible the cycle after its last pixel.
// Single output stage: in_ready = !out_valid || out_ready, full rate when the consumer keeps up.
module pool_window_stream9
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 20
) (
  input  logic                clk,
  input  logic                reset,
  pool_window_stream9_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;

  logic accept, emit, last_col, last_row;
  logic [LB_ROWS-1:0][DATA_WIDTH-1:0] lb_col;
  logic [0:K*K*DATA_WIDTH-1] win_flat;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_col     = (col_q == CW'(IMG_W - 1));
  assign last_row     = (row_q == RW'(IMG_H - 1));
  assign emit         = accept && (row_q >= RW'(LB_ROWS)) && (col_q >= CW'(LB_ROWS));

  pool_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .IMG_W     (IMG_W),
    .CW        (CW)
  ) u_lb (
    .clk    (clk),
    .wr_en_i(accept),
    .col_i  (col_q),
    .din_i  (bus.in_data),
    .col_o  (lb_col)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < LB_ROWS; r++) begin
        win_d[r][K-1] = lb_col[r];
      end
      win_d[K-1][K-1] = bus.in_data;
    end

    // Accepts only happen when the output slot is free or being drained,
    // so the window register itself serves as the held output.
    if (emit) begin
      out_valid_d = 1'b1;
      out_last_d  = last_row && last_col;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end

  assign bus.out_window = win_flat;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_pool_window_stream9.sv
// Directed bench for pool_window_stream9 on a 10x10 frame with a window scoreboard.
module tb_pool_window_stream9;
  localparam int KK = 9;
  localparam int DW = 16;
  localparam int W  = 10;
  localparam int H  = 10;
  localparam int NW = KK * KK * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool_window_stream9_if #(.DATA_WIDTH(DW)) bus ();

  pool_window_stream9 #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests    = 0;
  int fails    = 0;
  int win_seen = 0;
  logic [0:NW-1] exp_q[$];
  bit            last_q[$];

  function automatic logic [0:NW-1] model_win(input int base, input int r, input int c);
    logic [0:NW-1] w;
    w = '0;
    for (int i = 0; i < KK; i++)
      for (int j = 0; j < KK; j++)
        w[(i*KK+j)*DW +: DW] = DW'(base + (r - 8 + i) * 16 + (c - 8 + j));
    return w;
  endfunction

  function automatic logic [DW-1:0] elem(input logic [0:NW-1] w, input int r, input int c);
    return w[(r*KK+c)*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [0:NW-1] got, input logic [0:NW-1] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: a window shown with out_ready high is consumed at the next edge.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.out_valid && bus.out_ready) begin
      win_seen++;
      check("window_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_win("window_data", bus.out_window, exp_q.pop_front());
        check("window_last", bus.out_last, last_q.pop_front());
      end
    end
  end

  task automatic push(input int base, input int r, input int c);
    int budget;
    bit done;
    budget = 0;
    done   = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(base + r * 16 + c);
    while (!done && budget < 50) begin
      #1;
      if (bus.in_ready) begin
        done = 1'b1;
        if (r >= 8 && c >= 8) begin
          exp_q.push_back(model_win(base, r, c));
          last_q.push_back(r == H - 1 && c == W - 1);
        end
      end
      @(negedge clk);
      budget++;
    end
    bus.in_valid = 1'b0;
    check("push_accepted", done, 1);
  endtask

  task automatic hold_output();
    logic [0:NW-1] snap;
    bus.out_ready = 1'b0;
    snap = bus.out_window;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_valid", bus.out_valid, 1);
      check_win("hold_window", bus.out_window, snap);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic send_frame(input int base, input int npix, input bit gaps, input bit hold);
    for (int p = 0; p < npix; p++) begin
      int r, c;
      r = p / W;
      c = p % W;
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
      push(base, r, c);
      if (r == 8 && c == 8) begin
        #1;
        check("first_emit_valid", bus.out_valid, 1);
        check("first_emit_e88", elem(bus.out_window, 8, 8), DW'(base + 16'h88));
        check("first_emit_e00", elem(bus.out_window, 0, 0), DW'(base));
        if (hold) hold_output();
      end
    end
  endtask

  task automatic drain(input int nwin);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("window_count", win_seen, nwin);
    win_seen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check_win("rst_out_window", bus.out_window, '0);
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // full-speed frame
    send_frame(0, W * H, 1'b0, 1'b0);
    drain(4);

    // backpressure after window 0
    send_frame(0, W * H, 1'b0, 1'b1);
    drain(4);

    // random input gaps
    send_frame(0, W * H, 1'b1, 1'b0);
    drain(4);

    // back-to-back frames, no idle between them
    send_frame(0, W * H, 1'b0, 1'b0);
    send_frame(16'h100, W * H, 1'b0, 1'b0);
    drain(8);

    // reset in the middle of a frame
    send_frame(0, 55, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    win_seen = 0;
    send_frame(16'h200, W * H, 1'b0, 1'b0);
    drain(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pool_window_stream9.md
# pool_window_stream9

Streaming 9x9 window generator for the SPP max-pool path. It accepts a raster-ordered feature-map pixel stream, one pixel per handshake. For every stride-1, unpadded 9x9 window position it emits the complete window as one flattened vector. The vector is laid out exactly as the 9x9 max-pool unit consumes it. The block sits between the conv output stream and the combinational 9x9 pooling logic, and supplies the window data that logic reads.

## Interface
- DATA_WIDTH, 16, bits per pixel
- IMG_W, 20, feature-map width in pixels (≥ 9)
- IMG_H, 20, feature-map height in pixels (≥ 9)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  DATA_WIDTH  pixel, raster order (row-major, col fastest)
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts pixel this cycle
- out_window  out  [0:81*DATA_WIDTH-1]  window; element (r,c) at bits (r*9+c)*DATA_WIDTH +: DATA_WIDTH, r=0 top row, c=0 leftmost
- out_valid  out  1  out_window holds an unconsumed window
- out_ready  in  1  consumer takes window
- out_last  out  1  qualifies out_valid: final window of frame

## Operation
- Accept = in_valid && in_ready. Non-accept cycles change no state except the output handshake.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel.
- On accept, col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0, ready for the next frame with no idle gap.
- Line buffer: 8 rows × IMG_W entries. Entry lb[k][col] holds pixel (row-8+k, col).
- Column formation on accept: new column = {lb[0][col] … lb[7][col], in_data}, top to bottom.
- Line buffer update on accept: lb[k][col] ← lb[k+1][col] for k<7, and lb[7][col] ← in_data.
- Window register (9x9) on accept: shifts left one column; the new column enters at c=8.
- Emission: if the accepted pixel has row ≥ 8 and col ≥ 8, the updated window is presented on the next cycle with out_valid=1.
  - out_last=1 iff that pixel is (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_H-8)*(IMG_W-8), in raster order of their top-left corner.
- Stale columns from the previous row are always flushed before col reaches 8. No masking is needed.
- Line buffer contents are undefined after reset. They are never emitted before being overwritten.

## Timing
- Reset values: out_valid=0, out_last=0, out_window=0, col=row=0, in_ready=1 in the cycle after reset.
- in_ready = !out_valid || out_ready (combinational). This gives a single output stage with no bubble at full throughput.
- Latency: pixel accepted in cycle t completes its window, which is visible from cycle t+1.
- Output hold: out_window and out_last hold stable while out_valid && !out_ready.
- out_valid clears after out_ready unless a new window is produced in the same cycle.
- Simultaneous consume + accept producing a window: out_valid stays 1 and out_window updates. No drop, no duplicate.
- Throughput: 1 pixel/cycle when out_ready is held high.
- Reset mid-frame: all partial state is discarded. The next accepted pixel is (0,0) of a new frame, and no window from the old frame is emitted.

## Structure
- Shared package pool_pkg holds:
  - localparam K=9, LB_ROWS=K-1;
  - function win_idx(r,c) = (r*K+c), used for the out_window bit position.
- Sub-module pool_line_buffer: an 8×IMG_W register/RAM array. It reads column col and writes the shifted column on accept.
- Counters, window register and handshake live in the top module.

## Test plan
Use IMG_W=IMG_H=10 and pixel value = row*16+col unless stated otherwise.

- **Full-speed frame.** Stream 100 pixels with out_ready=1.
  - Exactly 4 windows are emitted.
  - Window 0 element (r,c) = r*16+c.
  - Window 3 element (r,c) = (r+1)*16+(c+1); out_last=1 only on window 3.
- **Latency and first emit.** Accept pixel (8,8) at cycle t.
  - out_valid rises at t+1, with element (8,8)=0x88 and (0,0)=0x00.
- **Backpressure.** Hold out_ready=0 for 5 cycles after window 0.
  - in_ready=0 and out_window is stable throughout.
  - On release, windows 1..3 follow in order with no loss.
- **Input gaps.** Randomly deassert in_valid on 50% of cycles.
  - Window contents are identical to the full-speed case.
- **Back-to-back frames.** Second frame pixel value = 0x100+row*16+col.
  - Its window 0 element (0,0)=0x100, and no old-frame data appears.
- **Reset mid-frame.** Assert reset after 55 pixels, then send a fresh frame.
  - out_valid=0 in the cycle after reset.
  - Exactly 4 correct windows are emitted for the new frame.
